button_debouncer: RTL
=====================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter NUM_BTN, default 4: number of independent button channels.
REQ-002 Parameter STABLE_TICKS, default 4 (legal range 1..15): consecutive debounce ticks a new raw level must hold before it is accepted.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 debounce_clk  input  1  slow square wave from the clock divider, synchronous to clk and high for half its period; a debounce tick is its rising edge.
REQ-006 btn_raw  input  NUM_BTN  raw, bouncy, asynchronous button levels; 1 = pressed.
REQ-007 btn_level  output  NUM_BTN  debounced level per button, registered.
REQ-008 btn_press  output  NUM_BTN  one-clk pulse per accepted 0->1 transition, registered.
REQ-009 btn_release  output  NUM_BTN  one-clk pulse per accepted 1->0 transition, registered.

Function
REQ-010 The block SHALL register debounce_clk once (dclk_q) and form tick = debounce_clk & ~dclk_q, so tick is high for exactly one clk cycle per debounce_clk rising edge.
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchronizer; only the second-stage value (btn_sync) feeds the per-channel logic.
REQ-012 Each channel SHALL own an FSM with states STABLE_LO, CHK_HI, STABLE_HI, CHK_LO and a counter of width ceil(log2(STABLE_TICKS+1)).
REQ-013 The FSM and counter SHALL advance only in cycles where tick = 1 and hold otherwise.
REQ-014 On a tick in STABLE_LO with btn_sync = 1, the FSM SHALL go to CHK_HI with counter = 1; with btn_sync = 0 it SHALL stay in STABLE_LO.
REQ-015 On a tick in CHK_HI with btn_sync = 1 and counter = STABLE_TICKS-1, the FSM SHALL go to STABLE_HI and set btn_level = 1.
REQ-016 On a tick in CHK_HI with btn_sync = 1 and counter < STABLE_TICKS-1, the counter SHALL increment.
REQ-017 On a tick in CHK_HI with btn_sync = 0, the FSM SHALL return to STABLE_LO with counter = 0, producing no level change and no pulse.
REQ-018 STABLE_HI and CHK_LO SHALL mirror REQ-014..017 with polarities inverted; acceptance in CHK_LO sets btn_level = 0.
REQ-019 If STABLE_TICKS = 1, a tick in STABLE_LO or STABLE_HI that sees the opposite level SHALL accept it directly, without entering CHK_HI or CHK_LO.
REQ-020 The net acceptance latency SHALL be STABLE_TICKS ticks of the opposite level, counted from the first tick that samples it.
REQ-021 btn_level SHALL change in the clk cycle after the accepting tick.
REQ-022 btn_press (or btn_release) SHALL be high in that same cycle for exactly one clk and low otherwise.
REQ-023 btn_press and btn_release of the same channel SHALL never both be high.
REQ-024 Channels SHALL be fully independent; simultaneous acceptances on several channels SHALL each pulse in the same cycle.
REQ-025 The counter SHALL never exceed STABLE_TICKS-1 and SHALL never wrap.
REQ-026 Raw changes between ticks SHALL be ignored; only the level sampled at each tick counts.

Reset
REQ-027 While rst_n = 0, the following SHALL be 0 immediately, independent of clk: synchronizer flops, dclk_q, all counters, btn_level, btn_press and btn_release.
REQ-028 While rst_n = 0, every FSM SHALL be in STABLE_LO.
REQ-029 Assertion of rst_n mid-check SHALL discard the partial count; a button held through reset release SHALL be re-qualified from STABLE_LO, yielding one btn_press after STABLE_TICKS ticks.
REQ-030 The first debounce_clk rising edge seen after reset release SHALL count as a tick only if dclk_q was 0 in the preceding cycle.

Verification
REQ-031 Clean press: STABLE_TICKS = 4, btn_raw[0] 0->1 and held -> btn_level[0] = 1 and btn_press[0] pulses once, 1 clk after the 4th tick sampling 1.
REQ-032 Bounce reject: btn_raw[1] high for 2 ticks, low for 1 tick, then high -> no pulse after the first 2 ticks; press accepted 4 ticks after the final rise.
REQ-033 Release: btn_raw[0] held high and then dropped for 4 ticks -> btn_level[0] = 0 and btn_release[0] pulses once; btn_press[0] stays 0.
REQ-034 Simultaneous events: btn_raw[3:0] = 4'b1111 in the same cycle -> all four btn_press bits pulse in the same clk cycle.
REQ-035 Reset mid-check: rst_n pulsed low after 2 ticks of a press -> all outputs 0 at once; with the button held, btn_press occurs 4 ticks after rst_n rises.
REQ-036 Tick gating: debounce_clk held high for many clk cycles -> exactly one tick counted; btn_raw glitches between ticks leave btn_level and the pulse outputs unchanged.

Source files
------------

// File: rtl/button_debouncer.sv
// Debounces NUM_BTN raw buttons: 2-flop sync, then per-channel tick-qualified FSM.
// Latency: 2 clk sync + STABLE_TICKS debounce ticks; level/pulse change 1 clk after the accepting tick.
// No backpressure: btn_press/btn_release are single-cycle pulses, never held or queued.
module button_debouncer #(
    parameter int NUM_BTN      = 4,
    parameter int STABLE_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               debounce_clk,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    localparam logic [1:0] STABLE_LO = 2'd0;
    localparam logic [1:0] CHK_HI    = 2'd1;
    localparam logic [1:0] STABLE_HI = 2'd2;
    localparam logic [1:0] CHK_LO    = 2'd3;

    logic               dclk_q;
    logic               tick;
    logic [NUM_BTN-1:0] sync_q1;
    logic [NUM_BTN-1:0] btn_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dclk_q   <= 1'b0;
            sync_q1  <= '0;
            btn_sync <= '0;
        end else begin
            dclk_q   <= debounce_clk;
            sync_q1  <= btn_raw;
            btn_sync <= sync_q1;
        end
    end

    // One-cycle strobe on each debounce_clk rising edge, however long it stays high.
    assign tick = debounce_clk & ~dclk_q;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        logic [1:0]       state;
        logic [CNT_W-1:0] cnt;
        logic             level_q;
        logic             press_q;
        logic             release_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= STABLE_LO;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                if (tick) begin
                    case (state)
                        STABLE_LO: begin
                            if (btn_sync[g]) begin
                                // A single-tick qualification accepts on the very first sample.
                                if (STABLE_TICKS == 1) begin
                                    state   <= STABLE_HI;
                                    level_q <= 1'b1;
                                    press_q <= 1'b1;
                                end else begin
                                    state <= CHK_HI;
                                    cnt   <= CNT_ONE;
                                end
                            end
                        end
                        CHK_HI: begin
                            if (!btn_sync[g]) begin
                                state <= STABLE_LO;
                                cnt   <= '0;
                            end else if (cnt == CNT_LAST) begin
                                state   <= STABLE_HI;
                                cnt     <= '0;
                                level_q <= 1'b1;
                                press_q <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                        STABLE_HI: begin
                            if (!btn_sync[g]) begin
                                if (STABLE_TICKS == 1) begin
                                    state     <= STABLE_LO;
                                    level_q   <= 1'b0;
                                    release_q <= 1'b1;
                                end else begin
                                    state <= CHK_LO;
                                    cnt   <= CNT_ONE;
                                end
                            end
                        end
                        CHK_LO: begin
                            if (btn_sync[g]) begin
                                state <= STABLE_HI;
                                cnt   <= '0;
                            end else if (cnt == CNT_LAST) begin
                                state     <= STABLE_LO;
                                cnt       <= '0;
                                level_q   <= 1'b0;
                                release_q <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                        default: begin
                            state <= STABLE_LO;
                            cnt   <= '0;
                        end
                    endcase
                end
            end
        end

        assign btn_level[g]   = level_q;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = release_q;
    end

endmodule
